tff_seq_ctrl: RTL

Command-driven sequencer for a bank of WIDTH T flip-flops. Accepts LOAD/INC/CLR/INV commands over a valid/ready handshake and converts each into a one-cycle toggle vector driven onto the bank's T inputs. It then reads the bank's Q outputs back and confirms the expected value was reached. It sits between a register/control master and the T flip-flop bank, which owns no logic of its own.

---
 rtl/tff_seq_pkg.sv | 12 +
 rtl/tff_mask_gen.sv | 20 ++
 rtl/tff_seq_ctrl.sv | 92 +++++++++
 3 files changed

// File: rtl/tff_seq_pkg.sv
// tff_seq_pkg: op encodings and controller state type; STEP exists only with TFF_STEP_EN.
package tff_seq_pkg;
    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_INC  = 2'd1;
    localparam logic [1:0] OP_CLR  = 2'd2;
    localparam logic [1:0] OP_INV  = 2'd3;
`ifdef TFF_STEP_EN
    typedef enum logic [1:0] {IDLE, APPLY, CHECK, STEP} state_t;
`else
    typedef enum logic [1:0] {IDLE, APPLY, CHECK} state_t;
`endif
endpackage

// File: rtl/tff_mask_gen.sv
// tff_mask_gen: toggle mask and INC wrap flag from op, current bank value and LOAD data.
module tff_mask_gen
    import tff_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] mask,
    output logic             wrap
);
    logic [WIDTH:0] inc;
    assign inc  = {1'b0, q} + (WIDTH+1)'(1);
    assign mask = op == OP_LOAD ? data ^ q
                : op == OP_INC  ? q ^ inc[WIDTH-1:0]
                : op == OP_CLR  ? q
                : '1;
    assign wrap = op == OP_INC && inc[WIDTH];
endmodule

// File: rtl/tff_seq_ctrl.sv
// tff_seq_ctrl: command sequencer driving a T flip-flop bank and verifying its readback.
// TFF_STEP_EN: LOAD/CLR/INV toggle one bit per cycle through a STEP state.
module tff_seq_ctrl
    import tff_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] t_out,
    input  logic [WIDTH-1:0] q_in,
    output logic             done,
    output logic             wrap,
    output logic             err
);
    state_t           state;
    logic [WIDTH-1:0] expected, mask_nxt;
    logic             wrap_pending, wrap_nxt;

    tff_mask_gen #(.WIDTH(WIDTH)) u_mask (
        .op   (cmd_op),
        .q    (q_in),
        .data (cmd_data),
        .mask (mask_nxt),
        .wrap (wrap_nxt)
    );

    assign cmd_ready = state == IDLE;
    assign done      = state == CHECK;
    assign wrap      = done && wrap_pending;

`ifdef TFF_STEP_EN
    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH-1);
    logic [WIDTH-1:0] mask;
    logic [IW-1:0]    idx, nxt;
    assign nxt = idx + IW'(1);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            t_out        <= '0;
            expected     <= '0;
            wrap_pending <= 1'b0;
            err          <= 1'b0;
`ifdef TFF_STEP_EN
            mask         <= '0;
            idx          <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    expected     <= q_in ^ mask_nxt;
                    wrap_pending <= wrap_nxt;
`ifdef TFF_STEP_EN
                    mask         <= mask_nxt;
                    idx          <= '0;
                    state        <= cmd_op == OP_INC ? APPLY : STEP;
                    t_out        <= cmd_op == OP_INC ? mask_nxt : {{(WIDTH-1){1'b0}}, mask_nxt[0]};
`else
                    state        <= APPLY;
                    t_out        <= mask_nxt;
`endif
                end
                APPLY: begin
                    state <= CHECK;
                    t_out <= '0;
                end
                CHECK: begin
                    state <= IDLE;
                    err   <= err | (q_in != expected);
                end
`ifdef TFF_STEP_EN
                // one bank bit per cycle keeps simultaneous switching to a single flop
                STEP: if (idx == LAST) begin
                    state <= CHECK;
                    t_out <= '0;
                end else begin
                    idx   <= nxt;
                    t_out <= WIDTH'(mask[nxt]) << nxt;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule
